snn_inference_sequencer: RTL

// Top-level scheduler for one SNN inference. On request it triggers image_loader, waits for load done,

---
 rtl/snn_pkg.sv | 20 ++
 rtl/spike_argmax_unit.sv | 93 +++++++++
 rtl/snn_inference_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN inference sequencer: default sizing and FSM state encoding.
package snn_pkg;

    localparam int NUM_TIMESTEPS  = 20;
    localparam int NUM_CLASSES    = 10;
    localparam int TIMEOUT_CYCLES = 4096;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_REQ  = 4'd1,
        LOAD_WAIT = 4'd2,
        CLEAR     = 4'd3,
        STEP_REQ  = 4'd4,
        STEP_WAIT = 4'd5,
        ARGMAX    = 4'd6,
        DONE      = 4'd7,
        ERR       = 4'd8
    } state_t;

endpackage

// File: rtl/spike_argmax_unit.sv
// Per-class saturating spike counters plus a one-class-per-cycle argmax scan.
// The scan keeps the first class holding the maximum (strict '>' update), so ties
// resolve to the lowest index and an all-zero histogram yields class 0.
module spike_argmax_unit
    import snn_pkg::*;
#(
    parameter int P_NUM_CLASSES = NUM_CLASSES,
    parameter int P_CNT_BITS    = $clog2(NUM_TIMESTEPS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             accumulate,
    input  logic [P_NUM_CLASSES-1:0]         spikes,
    input  logic                             scan_start,
    output logic                             scan_done,
    output logic [$clog2(P_NUM_CLASSES)-1:0] scan_class
);

    localparam int CLS_W = $clog2(P_NUM_CLASSES);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(P_NUM_CLASSES - 1);

    logic [P_CNT_BITS-1:0] cnt_r [P_NUM_CLASSES];
    logic                  scanning_r;
    logic [CLS_W-1:0]      idx_r;
    logic [CLS_W-1:0]      best_idx_r;
    logic [P_CNT_BITS-1:0] best_cnt_r;
    logic [P_CNT_BITS-1:0] cur_cnt_s;
    logic [CLS_W-1:0]      cand_idx_s;
    logic [P_CNT_BITS-1:0] cand_cnt_s;

    // Add one when requested, but never wrap past all-ones.
    function automatic logic [P_CNT_BITS-1:0] sat_inc(input logic [P_CNT_BITS-1:0] val,
                                                      input logic inc);
        if (inc && (val != {P_CNT_BITS{1'b1}})) begin
            return val + P_CNT_BITS'(1);
        end else begin
            return val;
        end
    endfunction

    // Spike histogram: cleared at the start of an inference, bumped on each finished timestep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < P_NUM_CLASSES; c++) cnt_r[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < P_NUM_CLASSES; c++) cnt_r[c] <= '0;
        end else if (accumulate) begin
            for (int c = 0; c < P_NUM_CLASSES; c++) cnt_r[c] <= sat_inc(cnt_r[c], spikes[c]);
        end
    end

    // Compare the class under the scan pointer against the best seen so far.
    always_comb begin
        cur_cnt_s  = cnt_r[idx_r];
        cand_idx_s = best_idx_r;
        cand_cnt_s = best_cnt_r;
        if (cur_cnt_s > best_cnt_r) begin
            cand_idx_s = idx_r;
            cand_cnt_s = cur_cnt_s;
        end else begin
            cand_idx_s = best_idx_r;
            cand_cnt_s = best_cnt_r;
        end
    end

    // Scan pointer and running best; the last class is folded in combinationally via cand_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanning_r <= 1'b0;
            idx_r      <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
        end else if (scan_start) begin
            scanning_r <= 1'b1;
            idx_r      <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
        end else if (scanning_r) begin
            best_idx_r <= cand_idx_s;
            best_cnt_r <= cand_cnt_s;
            if (idx_r == LAST_CLS) begin
                scanning_r <= 1'b0;
            end else begin
                idx_r <= idx_r + CLS_W'(1);
            end
        end
    end

    assign scan_done  = scanning_r && (idx_r == LAST_CLS);
    assign scan_class = cand_idx_s;

endmodule

// File: rtl/snn_inference_sequencer.sv
// Schedules one SNN inference: image load, neuron clear, P_NUM_TIMESTEPS steps, argmax.
// Every output is a register written together with the state it belongs to, so each
// pulse is high exactly during the cycle the FSM sits in the matching state.
module snn_inference_sequencer
    import snn_pkg::*;
#(
    parameter int P_NUM_TIMESTEPS  = NUM_TIMESTEPS,
    parameter int P_NUM_CLASSES    = NUM_CLASSES,
    parameter int P_CNT_BITS       = $clog2(P_NUM_TIMESTEPS + 1),
    parameter int P_TIMEOUT_CYCLES = TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_infer_start,
    output logic                             o_load_image_start,
    input  logic                             i_load_done,
    output logic                             o_state_clear,
    output logic                             o_step_start,
    input  logic                             i_step_done,
    input  logic [P_NUM_CLASSES-1:0]         i_out_spikes,
    output logic [P_CNT_BITS-1:0]            o_timestep,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [$clog2(P_NUM_CLASSES)-1:0] o_pred_class,
    output logic                             o_error
);

    localparam int CLS_W = $clog2(P_NUM_CLASSES);
    localparam int TMO_W = $clog2(P_TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [P_CNT_BITS-1:0] TS_LAST  = P_CNT_BITS'(P_NUM_TIMESTEPS - 1);

    state_t                state_r, state_next_s;
    logic                  load_start_r, load_start_next_s;
    logic                  clear_r, clear_next_s;
    logic                  step_start_r, step_start_next_s;
    logic                  done_r, done_next_s;
    logic                  error_r, error_next_s;
    logic                  busy_r, busy_next_s;
    logic [P_CNT_BITS-1:0] timestep_r, timestep_next_s;
    logic [CLS_W-1:0]      pred_r, pred_next_s;
    logic [TMO_W-1:0]      tmo_r, tmo_next_s;
    logic                  cnt_clear_s, cnt_acc_s, scan_start_s;
    logic                  scan_done_s;
    logic [CLS_W-1:0]      scan_class_s;

    spike_argmax_unit #(
        .P_NUM_CLASSES (P_NUM_CLASSES),
        .P_CNT_BITS    (P_CNT_BITS)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear_s),
        .accumulate (cnt_acc_s),
        .spikes     (i_out_spikes),
        .scan_start (scan_start_s),
        .scan_done  (scan_done_s),
        .scan_class (scan_class_s)
    );

    // Next state, next registered outputs and datapath strobes for the argmax unit.
    always_comb begin
        state_next_s      = state_r;
        load_start_next_s = 1'b0;
        clear_next_s      = 1'b0;
        step_start_next_s = 1'b0;
        done_next_s       = 1'b0;
        error_next_s      = 1'b0;
        busy_next_s       = busy_r;
        timestep_next_s   = timestep_r;
        pred_next_s       = pred_r;
        tmo_next_s        = tmo_r;
        cnt_clear_s       = 1'b0;
        cnt_acc_s         = 1'b0;
        scan_start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_infer_start) begin
                    state_next_s      = LOAD_REQ;
                    load_start_next_s = 1'b1;
                    busy_next_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_REQ: begin
                state_next_s = LOAD_WAIT;
                tmo_next_s   = '0;
            end
            LOAD_WAIT: begin
                // A done pulse in the expiry cycle still counts as success.
                if (i_load_done) begin
                    state_next_s = CLEAR;
                    clear_next_s = 1'b1;
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ERR;
                    error_next_s = 1'b1;
                    busy_next_s  = 1'b0;
                end else begin
                    tmo_next_s = tmo_r + TMO_W'(1);
                end
            end
            CLEAR: begin
                state_next_s      = STEP_REQ;
                step_start_next_s = 1'b1;
                timestep_next_s   = '0;
                cnt_clear_s       = 1'b1;
            end
            STEP_REQ: begin
                state_next_s = STEP_WAIT;
                tmo_next_s   = '0;
            end
            STEP_WAIT: begin
                if (i_step_done) begin
                    cnt_acc_s = 1'b1;
                    if (timestep_r == TS_LAST) begin
                        state_next_s = ARGMAX;
                        scan_start_s = 1'b1;
                    end else begin
                        state_next_s      = STEP_REQ;
                        step_start_next_s = 1'b1;
                        timestep_next_s   = timestep_r + P_CNT_BITS'(1);
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ERR;
                    error_next_s = 1'b1;
                    busy_next_s  = 1'b0;
                end else begin
                    tmo_next_s = tmo_r + TMO_W'(1);
                end
            end
            ARGMAX: begin
                if (scan_done_s) begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                    pred_next_s  = scan_class_s;
                    busy_next_s  = 1'b0;
                end else begin
                    state_next_s = ARGMAX;
                end
            end
            DONE:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State, output and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            load_start_r <= 1'b0;
            clear_r      <= 1'b0;
            step_start_r <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            busy_r       <= 1'b0;
            timestep_r   <= '0;
            pred_r       <= '0;
            tmo_r        <= '0;
        end else begin
            state_r      <= state_next_s;
            load_start_r <= load_start_next_s;
            clear_r      <= clear_next_s;
            step_start_r <= step_start_next_s;
            done_r       <= done_next_s;
            error_r      <= error_next_s;
            busy_r       <= busy_next_s;
            timestep_r   <= timestep_next_s;
            pred_r       <= pred_next_s;
            tmo_r        <= tmo_next_s;
        end
    end

    assign o_load_image_start = load_start_r;
    assign o_state_clear      = clear_r;
    assign o_step_start       = step_start_r;
    assign o_done             = done_r;
    assign o_error            = error_r;
    assign o_busy             = busy_r;
    assign o_timestep         = timestep_r;
    assign o_pred_class       = pred_r;

endmodule
